p_hit_sched: RTL

P_HIT_SCHED -- requirements
Module: p_hit_sched

---
 rtl/p_hit_sched.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/p_hit_sched.sv
// rtl/p_hit_sched.sv - round-robin job issue and in-order result return for a shared p_hit unit; optional counters under P_HIT_SCHED_STATS_EN
module p_hit_sched #(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic signed [NUM_REQ-1:0][2:0][31:0] req_tri_normal_1,
  input  logic signed [NUM_REQ-1:0][2:0][31:0] req_tri_normal_2,
  input  logic signed [NUM_REQ-1:0][2:0][31:0] req_v0,
  input  logic signed [NUM_REQ-1:0][2:0][31:0] req_origin,
  input  logic signed [NUM_REQ-1:0][2:0][31:0] req_dir,
  output logic signed [2:0][31:0]              tri_normal_1,
  output logic signed [2:0][31:0]              tri_normal_2,
  output logic signed [2:0][31:0]              v0,
  output logic signed [2:0][31:0]              origin_1,
  output logic signed [2:0][31:0]              origin_2,
  output logic signed [2:0][31:0]              dir_1,
  output logic signed [2:0][31:0]              dir_2,
  output logic [3:0]                           in_wr_en,
  input  logic [3:0]                           in_full,
  input  logic signed [2:0][31:0]              ph_out,
  input  logic                                 ph_out_empty,
  output logic                                 ph_out_rd_en,
  output logic signed [2:0][31:0]              res_data,
  output logic [NUM_REQ-1:0]                   res_valid,
  input  logic [NUM_REQ-1:0]                   res_ready,
  output logic                                 tag_err
`ifdef P_HIT_SCHED_STATS_EN
  ,
  output logic [31:0]                          stat_issued,
  output logic [31:0]                          stat_retired,
  output logic [31:0]                          stat_stall
`endif
);

  localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    RET_IDLE,
    RET_HOLD
  } ret_state_t;

  ret_state_t    state;
  ret_state_t    state_next;

  logic [TW-1:0] last_grant;
  logic [TW-1:0] grant;
  logic [TW-1:0] rr_idx;
  logic          grant_found;
  logic          issue;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] tag_cnt;
  logic [TW-1:0] tag_mem [MAX_OUTSTANDING];
  logic [AW-1:0] tag_wr_ptr;
  logic [AW-1:0] tag_rd_ptr;
  logic          tag_full;
  logic          tag_empty;

  logic          pop;
  logic          retire;
  logic          orphan;
  logic [TW-1:0] hold_tag;

  // Walk the requesters starting just after the last winner, wrapping at NUM_REQ-1.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    rr_idx      = last_grant;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_idx = (rr_idx == TW'(NUM_REQ - 1)) ? '0 : rr_idx + TW'(1);
      if (!grant_found && req_valid[rr_idx]) begin
        grant       = rr_idx;
        grant_found = 1'b1;
      end
    end
  end

  assign tag_full  = (tag_cnt == CW'(MAX_OUTSTANDING));
  assign tag_empty = (tag_cnt == '0);

  assign issue = !reset && grant_found && (in_full == 4'b0000) &&
                 (outstanding < CW'(MAX_OUTSTANDING)) && !tag_full;

  assign in_wr_en = {4{issue}};

  always_comb begin
    req_ready = '0;
    if (issue) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign tri_normal_1 = req_tri_normal_1[grant];
  assign tri_normal_2 = req_tri_normal_2[grant];
  assign v0           = req_v0[grant];
  assign origin_1     = req_origin[grant];
  assign origin_2     = req_origin[grant];
  assign dir_1        = req_dir[grant];
  assign dir_2        = req_dir[grant];

  // A result is popped only from IDLE, so the retire cycle can never pop again.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    retire     = 1'b0;
    orphan     = 1'b0;
    res_valid  = '0;
    if (!reset) begin
      case (state)
        RET_IDLE: begin
          if (!ph_out_empty) begin
            if (!tag_empty) begin
              pop        = 1'b1;
              state_next = RET_HOLD;
            end else begin
              orphan = 1'b1;
            end
          end
        end
        RET_HOLD: begin
          res_valid[hold_tag] = 1'b1;
          if (res_ready[hold_tag]) begin
            retire     = 1'b1;
            state_next = RET_IDLE;
          end
        end
        default: state_next = RET_IDLE;
      endcase
    end
  end

  assign ph_out_rd_en = pop;

  always_ff @(posedge clock) begin
    if (issue) begin
      tag_mem[tag_wr_ptr] <= grant;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RET_IDLE;
      last_grant  <= TW'(NUM_REQ - 1);
      outstanding <= '0;
      tag_cnt     <= '0;
      tag_wr_ptr  <= '0;
      tag_rd_ptr  <= '0;
      hold_tag    <= '0;
      res_data    <= '0;
      tag_err     <= 1'b0;
    end else begin
      state <= state_next;
      if (issue) begin
        last_grant <= grant;
        tag_wr_ptr <= tag_wr_ptr + AW'(1);
      end
      if (pop) begin
        res_data   <= ph_out;
        hold_tag   <= tag_mem[tag_rd_ptr];
        tag_rd_ptr <= tag_rd_ptr + AW'(1);
      end
      case ({issue, pop})
        2'b10:   tag_cnt <= tag_cnt + CW'(1);
        2'b01:   tag_cnt <= tag_cnt - CW'(1);
        default: tag_cnt <= tag_cnt;
      endcase
      // Outstanding covers jobs until the requester accepts the result, not just until the pop.
      case ({issue, retire})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (orphan) begin
        tag_err <= 1'b1;
      end
    end
  end

`ifdef P_HIT_SCHED_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_issued  <= '0;
      stat_retired <= '0;
      stat_stall   <= '0;
    end else begin
      if (issue) begin
        stat_issued <= stat_issued + 32'd1;
      end
      if (retire) begin
        stat_retired <= stat_retired + 32'd1;
      end
      if (|req_valid && !issue) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule
